// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the coordinate-width helper used by the
// raster timing generator.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int unsigned VGA640_H_DISPLAY = 640;
    localparam int unsigned VGA640_H_FRONT   = 16;
    localparam int unsigned VGA640_H_SYNC    = 96;
    localparam int unsigned VGA640_H_BACK    = 48;
    localparam int unsigned VGA640_V_DISPLAY = 480;
    localparam int unsigned VGA640_V_FRONT   = 10;
    localparam int unsigned VGA640_V_SYNC    = 2;
    localparam int unsigned VGA640_V_BACK    = 33;
    localparam int unsigned VGA640_H_TOTAL   = VGA640_H_DISPLAY + VGA640_H_FRONT
                                             + VGA640_H_SYNC + VGA640_H_BACK;
    localparam int unsigned VGA640_V_TOTAL   = VGA640_V_DISPLAY + VGA640_V_FRONT
                                             + VGA640_V_SYNC + VGA640_V_BACK;

    // 800x600 @ 60 Hz, 40 MHz pixel clock (positive syncs)
    localparam int unsigned SVGA800_H_DISPLAY = 800;
    localparam int unsigned SVGA800_H_FRONT   = 40;
    localparam int unsigned SVGA800_H_SYNC    = 128;
    localparam int unsigned SVGA800_H_BACK    = 88;
    localparam int unsigned SVGA800_V_DISPLAY = 600;
    localparam int unsigned SVGA800_V_FRONT   = 1;
    localparam int unsigned SVGA800_V_SYNC    = 4;
    localparam int unsigned SVGA800_V_BACK    = 23;
    localparam int unsigned SVGA800_H_TOTAL   = SVGA800_H_DISPLAY + SVGA800_H_FRONT
                                              + SVGA800_H_SYNC + SVGA800_H_BACK;
    localparam int unsigned SVGA800_V_TOTAL   = SVGA800_V_DISPLAY + SVGA800_V_FRONT
                                              + SVGA800_V_SYNC + SVGA800_V_BACK;

    // Smallest coordinate width that can hold 0..total-1 on both axes.
    function automatic int unsigned coord_width(input int unsigned h_total,
                                                input int unsigned v_total);
        int unsigned m;
        m = (h_total > v_total) ? h_total : v_total;
        return (m <= 1) ? 32'd1 : 32'($clog2(m));
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// System-clock to pixel-rate divider; step_c pulses on the clock whose edge
// wraps the divider back to zero.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic step_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign step_c = enable && (div_cnt == DIV_LAST);

    // Holds its phase while disabled so a resume continues mid-pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= step_c ? '0 : div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel coordinates, sync pulses,
// line/frame strobes and a frame counter, all registered and cycle-aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY   = VGA640_H_DISPLAY,
    parameter int unsigned H_FRONT     = VGA640_H_FRONT,
    parameter int unsigned H_SYNC      = VGA640_H_SYNC,
    parameter int unsigned H_BACK      = VGA640_H_BACK,
    parameter int unsigned V_DISPLAY   = VGA640_V_DISPLAY,
    parameter int unsigned V_FRONT     = VGA640_V_FRONT,
    parameter int unsigned V_SYNC      = VGA640_V_SYNC,
    parameter int unsigned V_BACK      = VGA640_V_BACK,
    parameter int unsigned CLK_DIV     = 4,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned COORD_W     = coord_width(H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
                                                     V_DISPLAY + V_FRONT + V_SYNC + V_BACK),
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   display_on,
    output logic                   p_tick,
    output logic [COORD_W-1:0]     x_pos,
    output logic [COORD_W-1:0]     y_pos,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if ((64'(H_TOTAL) > (64'(1) << COORD_W)) || (64'(V_TOTAL) > (64'(1) << COORD_W))) begin : g_bad_coord_w
        $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
    end

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_DISP_C = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_DISP_C = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic                   step_c;
    logic [COORD_W-1:0]     x_nxt;
    logic [COORD_W-1:0]     y_nxt;
    logic [FRAME_CNT_W-1:0] fc_nxt;
    logic                   hs_act_nxt;
    logic                   vs_act_nxt;
    logic                   de_nxt;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .step_c (step_c)
    );

    // Next raster position; decode works on it so syncs line up with x/y.
    always_comb begin
        x_nxt  = x_pos + COORD_W'(1);
        y_nxt  = y_pos;
        fc_nxt = frame_count;
        if (x_pos == X_LAST) begin
            x_nxt = '0;
            if (y_pos == Y_LAST) begin
                y_nxt  = '0;
                fc_nxt = frame_count + FRAME_CNT_W'(1);
            end else begin
                y_nxt = y_pos + COORD_W'(1);
            end
        end
        hs_act_nxt = (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
        vs_act_nxt = (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
        de_nxt     = (x_nxt < H_DISP_C) && (y_nxt < V_DISP_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_pos       <= '0;
            y_pos       <= '0;
            frame_count <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            display_on  <= 1'b1;
            p_tick      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            p_tick      <= step_c;
            line_start  <= step_c && (x_nxt == '0);
            frame_start <= step_c && (x_nxt == '0) && (y_nxt == '0);
            if (step_c) begin
                x_pos       <= x_nxt;
                y_pos       <= y_nxt;
                frame_count <= fc_nxt;
                hsync       <= hs_act_nxt ? HSYNC_POL : ~HSYNC_POL;
                vsync       <= vs_act_nxt ? VSYNC_POL : ~VSYNC_POL;
                display_on  <= de_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line,
// reset and hold behaviour, and a tiny CLK_DIV=1 instance for whole frames.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       reset_a, enable_a;
    logic       hsync_a, vsync_a, display_on_a, p_tick_a, line_start_a, frame_start_a;
    logic [9:0] x_a, y_a;
    logic [7:0] fc_a;

    // Tiny instance: H 8/1/2/1 (12), V 4/1/1/1 (7), CLK_DIV=1, positive hsync
    logic       reset_b, enable_b;
    logic       hsync_b, vsync_b, display_on_b, p_tick_b, line_start_b, frame_start_b;
    logic [3:0] x_b, y_b;
    logic [1:0] fc_b;

    int n_checks = 0;
    int n_pass   = 0;

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .reset       (reset_a),
        .enable      (enable_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .display_on  (display_on_a),
        .p_tick      (p_tick_a),
        .x_pos       (x_a),
        .y_pos       (y_a),
        .line_start  (line_start_a),
        .frame_start (frame_start_a),
        .frame_count (fc_a)
    );

    vga_timing_gen #(
        .H_DISPLAY   (8),
        .H_FRONT     (1),
        .H_SYNC      (2),
        .H_BACK      (1),
        .V_DISPLAY   (4),
        .V_FRONT     (1),
        .V_SYNC      (1),
        .V_BACK      (1),
        .CLK_DIV     (1),
        .HSYNC_POL   (1'b1),
        .VSYNC_POL   (1'b0),
        .COORD_W     (4),
        .FRAME_CNT_W (2)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .enable      (enable_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .display_on  (display_on_b),
        .p_tick      (p_tick_b),
        .x_pos       (x_b),
        .y_pos       (y_b),
        .line_start  (line_start_b),
        .frame_start (frame_start_b),
        .frame_count (fc_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_x"},     32'(x_a), 0);
        check({tag, "_y"},     32'(y_a), 0);
        check({tag, "_hsync"}, 32'(hsync_a), 1);
        check({tag, "_vsync"}, 32'(vsync_a), 1);
        check({tag, "_de"},    32'(display_on_a), 1);
        check({tag, "_ptick"}, 32'(p_tick_a), 0);
        check({tag, "_fc"},    32'(fc_a), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_low, hs_min, hs_max, de_off_x, ticks, ls_cnt, ls_at, align_err, n;
        int frz_err;
        logic [9:0] x0;
        logic       hs0;
        int ex, ey, efc, pos_err, hs_err, vs_err, de_err, tick_err, strobe_err, fc_err;
        int fs_n;
        int fs_cyc[4];
        int fs_fc[4];

        reset_a  = 1'b1;
        reset_b  = 1'b1;
        enable_a = 1'b1;
        enable_b = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_a("por");

        // First pixel step lands on the 4th edge after release, at x=1
        reset_a = 1'b0;
        repeat (3) @(negedge clk);
        check("first_tick_early", 32'(p_tick_a), 0);
        @(negedge clk);
        check("first_tick", 32'(p_tick_a), 1);
        check("first_tick_x", 32'(x_a), 1);

        n = 0;
        while (!line_start_a && n < 4000) begin @(negedge clk); n++; end
        check("ls1_seen", 32'(line_start_a), 1);
        check("ls1_x", 32'(x_a), 0);
        check("ls1_y", 32'(y_a), 1);

        // One full line at default timing
        hs_low = 0; hs_min = 1023; hs_max = 0; de_off_x = -1;
        ticks = 0; ls_cnt = 0; ls_at = 0; align_err = 0;
        for (int c = 1; c <= 3200; c++) begin
            @(negedge clk);
            if (p_tick_a) ticks++;
            if (!hsync_a) begin
                hs_low++;
                if (int'(x_a) < hs_min) hs_min = int'(x_a);
                if (int'(x_a) > hs_max) hs_max = int'(x_a);
            end
            if (!display_on_a && de_off_x < 0) de_off_x = int'(x_a);
            if (hsync_a != !(x_a >= 10'd656 && x_a <= 10'd751)) align_err++;
            if (display_on_a != (x_a < 10'd640 && y_a < 10'd480)) align_err++;
            if (line_start_a) begin ls_cnt++; ls_at = c; end
        end
        check("hs_low_clks", 32'(hs_low), 384);
        check("hs_first_x", 32'(hs_min), 656);
        check("hs_last_x", 32'(hs_max), 751);
        check("de_off_x", 32'(de_off_x), 640);
        check("line_ticks", 32'(ticks), 800);
        check("line_align_err", 32'(align_err), 0);
        check("ls_count", 32'(ls_cnt), 1);
        check("ls_period", 32'(ls_at), 3200);
        check("ls2_x", 32'(x_a), 0);
        check("ls2_y", 32'(y_a), 2);

        // Asynchronous reset mid-line
        n = 0;
        while (x_a != 10'd300 && n < 2000) begin @(negedge clk); n++; end
        check("reach_x300", 32'(x_a), 300);
        reset_a = 1'b1;
        #1;
        check_reset_a("midline_rst");
        @(negedge clk);
        reset_a = 1'b0;
        repeat (3) @(negedge clk);
        check("rel_tick_early", 32'(p_tick_a), 0);
        @(negedge clk);
        check("rel_tick", 32'(p_tick_a), 1);
        check("rel_tick_x", 32'(x_a), 1);

        // Hold for 10 clocks with the divider at phase 2
        repeat (2) @(negedge clk);
        x0  = x_a;
        hs0 = hsync_a;
        enable_a = 1'b0;
        frz_err = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (x_a != x0 || y_a != 10'd0 || hsync_a != hs0 || vsync_a != 1'b1) frz_err++;
            if (p_tick_a || line_start_a || frame_start_a) frz_err++;
        end
        check("hold_err", 32'(frz_err), 0);
        enable_a = 1'b1;
        @(negedge clk);
        check("resume_no_tick", 32'(p_tick_a), 0);
        check("resume_x_held", 32'(x_a), 1);
        @(negedge clk);
        check("resume_tick", 32'(p_tick_a), 1);
        check("resume_x", 32'(x_a), 2);
        repeat (4) @(negedge clk);
        check("resume_tick2", 32'(p_tick_a), 1);
        check("resume_x2", 32'(x_a), 3);

        // Tiny instance: four whole frames at one pixel per clock
        check("b_rst_hsync", 32'(hsync_b), 0);
        check("b_rst_vsync", 32'(vsync_b), 1);
        reset_b = 1'b0;
        ex = 0; ey = 0; efc = 0;
        pos_err = 0; hs_err = 0; vs_err = 0; de_err = 0;
        tick_err = 0; strobe_err = 0; fc_err = 0; fs_n = 0;
        for (int c = 1; c <= 336; c++) begin
            @(negedge clk);
            ex++;
            if (ex == 12) begin
                ex = 0;
                if (ey == 6) begin ey = 0; efc = (efc + 1) % 4; end
                else ey++;
            end
            if (!p_tick_b) tick_err++;
            if (int'(x_b) != ex || int'(y_b) != ey) pos_err++;
            if (hsync_b != (ex >= 9 && ex <= 10)) hs_err++;
            if (vsync_b != (ey != 5)) vs_err++;
            if (display_on_b != (ex < 8 && ey < 4)) de_err++;
            if (line_start_b != (ex == 0) || frame_start_b != (ex == 0 && ey == 0)) strobe_err++;
            if (int'(fc_b) != efc) fc_err++;
            if (frame_start_b && fs_n < 4) begin
                fs_cyc[fs_n] = c;
                fs_fc[fs_n]  = int'(fc_b);
                fs_n++;
            end
        end
        check("b_tick_err", 32'(tick_err), 0);
        check("b_pos_err", 32'(pos_err), 0);
        check("b_hsync_err", 32'(hs_err), 0);
        check("b_vsync_err", 32'(vs_err), 0);
        check("b_de_err", 32'(de_err), 0);
        check("b_strobe_err", 32'(strobe_err), 0);
        check("b_fc_err", 32'(fc_err), 0);
        check("b_frames", 32'(fs_n), 4);
        check("b_fs0_cyc", 32'(fs_cyc[0]), 84);
        check("b_fs1_cyc", 32'(fs_cyc[1]), 168);
        check("b_fs2_cyc", 32'(fs_cyc[2]), 252);
        check("b_fs3_cyc", 32'(fs_cyc[3]), 336);
        check("b_fs0_fc", 32'(fs_fc[0]), 1);
        check("b_fs1_fc", 32'(fs_fc[1]), 2);
        check("b_fs2_fc", 32'(fs_fc[2]), 3);
        check("b_fs3_fc", 32'(fs_fc[3]), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
